// File: rtl/alu_exec_unit.sv
// Execution unit: single-cycle arithmetic/logic ops and bit-serial shifts/rotates,
// with valid/ready handshakes toward decode and toward writeback.
module alu_exec_unit #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [SHW-1:0]   in_shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_wen,
  output logic [3:0]       out_flags,
  output logic             out_illegal
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_MOV = 4'b0110;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  work_p1, work_d;
  logic [SHW-1:0]    cnt_p1, cnt_d;
  logic [1:0]        kind_p1, kind_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [3:0]        flags_q, flags_d;
  logic              wen_q, wen_d;
  logic              ill_q, ill_d;
  logic [WIDTH:0]    sum, diff;
  logic [WIDTH-1:0]  shift_nxt;
  logic              shift_out;

  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c,
                                          input logic v);
    return {r[WIDTH-1], (r == '0), c, v};
  endfunction

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] r);
    return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] r);
    return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  assign sum  = {1'b0, in_a} + {1'b0, in_b};
  assign diff = {1'b0, in_a} - {1'b0, in_b};

  // One-bit step of the working register; kind is op[1:0] of the shift group.
  always_comb begin
    shift_nxt = work_p1;
    shift_out = 1'b0;
    case (kind_p1)
      2'b00: begin shift_nxt = {work_p1[WIDTH-2:0], 1'b0};           shift_out = work_p1[WIDTH-1]; end
      2'b01: begin shift_nxt = {work_p1[WIDTH-2:0], work_p1[WIDTH-1]}; shift_out = work_p1[WIDTH-1]; end
      2'b10: begin shift_nxt = {1'b0, work_p1[WIDTH-1:1]};           shift_out = work_p1[0]; end
      default: begin shift_nxt = {work_p1[WIDTH-1], work_p1[WIDTH-1:1]}; shift_out = work_p1[0]; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_p1;
    cnt_d   = cnt_p1;
    kind_d  = kind_p1;
    res_d   = res_q;
    flags_d = flags_q;
    wen_d   = wen_q;
    ill_d   = ill_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = DONE;
          wen_d   = 1'b1;
          ill_d   = 1'b0;
          case (in_op)
            OP_ADD: begin
              res_d   = sum[WIDTH-1:0];
              flags_d = mk_flags(sum[WIDTH-1:0], sum[WIDTH], add_ovf(in_a, in_b, sum[WIDTH-1:0]));
            end
            OP_SUB, OP_CMP: begin
              res_d   = diff[WIDTH-1:0];
              flags_d = mk_flags(diff[WIDTH-1:0], diff[WIDTH], sub_ovf(in_a, in_b, diff[WIDTH-1:0]));
              wen_d   = (in_op != OP_CMP);
            end
            OP_AND: begin res_d = in_a & in_b; flags_d = mk_flags(in_a & in_b, 1'b0, 1'b0); end
            OP_OR:  begin res_d = in_a | in_b; flags_d = mk_flags(in_a | in_b, 1'b0, 1'b0); end
            OP_XOR: begin res_d = in_a ^ in_b; flags_d = mk_flags(in_a ^ in_b, 1'b0, 1'b0); end
            OP_MOV: begin res_d = in_b;        flags_d = mk_flags(in_b, 1'b0, 1'b0); end
            4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
              if (in_shamt == '0) begin
                res_d   = in_a;
                flags_d = mk_flags(in_a, 1'b0, 1'b0);
              end else begin
                work_d  = in_a;
                cnt_d   = in_shamt;
                kind_d  = in_op[1:0];
                state_d = SHIFT;
              end
            end
            default: begin
              res_d   = '0;
              flags_d = '0;
              wen_d   = 1'b0;
              ill_d   = 1'b1;
            end
          endcase
        end
      end
      SHIFT: begin
        work_d = shift_nxt;
        cnt_d  = cnt_p1 - SHW'(1);
        if (cnt_p1 == SHW'(1)) begin
          res_d   = shift_nxt;
          flags_d = mk_flags(shift_nxt, shift_out, 1'b0);
          state_d = DONE;
        end
      end
      default: begin
        if (out_ready) state_d = IDLE;
      end
    endcase
  end

  // Control and delivered-result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_p1  <= '0;
      kind_p1 <= '0;
      res_q   <= '0;
      flags_q <= '0;
      wen_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_p1  <= cnt_d;
      kind_p1 <= kind_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      wen_q   <= wen_d;
      ill_q   <= ill_d;
    end
  end

  // Working shift register: always reloaded before use, so no reset
  always_ff @(posedge clk) begin
    work_p1 <= work_d;
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_result  = res_q;
  assign out_flags   = flags_q;
  assign out_wen     = wen_q;
  assign out_illegal = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: vector table through a scoreboard queue, plus
// stall and reset-abort sequences.
module tb_alu_exec_unit;
  localparam int WIDTH = 16;
  localparam int SHW   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a, in_b;
  logic [SHW-1:0]   in_shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_wen;
  logic [3:0]       out_flags;
  logic             out_illegal;

  int n_chk  = 0;
  int n_fail = 0;

  alu_exec_unit #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_shamt(in_shamt),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_wen(out_wen), .out_flags(out_flags), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  sh;
    logic [15:0] res;
    logic [3:0]  fl;
    logic        wen;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  fl;
    logic        wen;
    logic        ill;
    int          lat;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                              input logic [3:0] sh, input logic [15:0] res, input logic [3:0] fl,
                              input logic wen, input logic ill);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.sh = sh; v.res = res; v.fl = fl; v.wen = wen; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input string tag, input vec_t v, input int stall);
    exp_t e;
    int   lat;
    @(negedge clk);
    out_ready = (stall == 0);
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1; in_op = v.op; in_a = v.a; in_b = v.b; in_shamt = v.sh;
    @(posedge clk);
    e.res = v.res; e.fl = v.fl; e.wen = v.wen; e.ill = v.ill;
    e.lat = (v.op[3:2] == 2'b10 && v.sh != 0) ? int'(v.sh) + 1 : 1;
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
    in_op = 4'($urandom); in_a = 16'($urandom); in_b = 16'($urandom); in_shamt = 4'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid) chk({tag, "_in_ready_busy"}, in_ready, 0);
    end while (!out_valid && lat < 64);
    e = sb.pop_front();
    if (!out_valid) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: no out_valid within %0d cycles", tag, lat);
      return;
    end
    chk({tag, "_latency"}, lat, e.lat);
    chk({tag, "_result"}, out_result, e.res);
    chk({tag, "_flags"}, out_flags, e.fl);
    chk({tag, "_wen"}, out_wen, e.wen);
    chk({tag, "_illegal"}, out_illegal, e.ill);
    chk({tag, "_in_ready_done"}, in_ready, 0);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk({tag, "_stall_valid"}, out_valid, 1);
      chk({tag, "_stall_result"}, out_result, e.res);
      chk({tag, "_stall_flags"}, out_flags, e.fl);
      chk({tag, "_stall_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_shamt = '0;
    out_ready = 1'b1;

    //            op       a         b         sh     res       {SZCV}   wen   ill
    tbl.push_back(mk(4'h0, 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 4'b1001, 1'b1, 1'b0));
    tbl.push_back(mk(4'h0, 16'hFFFF, 16'h0001, 4'd0, 16'h0000, 4'b0110, 1'b1, 1'b0));
    tbl.push_back(mk(4'h1, 16'h0003, 16'h0005, 4'd0, 16'hFFFE, 4'b1010, 1'b1, 1'b0));
    tbl.push_back(mk(4'h5, 16'h0003, 16'h0005, 4'd0, 16'hFFFE, 4'b1010, 1'b0, 1'b0));
    tbl.push_back(mk(4'h1, 16'h8000, 16'h0001, 4'd0, 16'h7FFF, 4'b0001, 1'b1, 1'b0));
    tbl.push_back(mk(4'h2, 16'hF0F0, 16'h3C3C, 4'd0, 16'h3030, 4'b0000, 1'b1, 1'b0));
    tbl.push_back(mk(4'h2, 16'h00FF, 16'hFF00, 4'd0, 16'h0000, 4'b0100, 1'b1, 1'b0));
    tbl.push_back(mk(4'h3, 16'h1200, 16'h0034, 4'd0, 16'h1234, 4'b0000, 1'b1, 1'b0));
    tbl.push_back(mk(4'h4, 16'hAAAA, 16'h5555, 4'd0, 16'hFFFF, 4'b1000, 1'b1, 1'b0));
    tbl.push_back(mk(4'h6, 16'h1111, 16'h8001, 4'd0, 16'h8001, 4'b1000, 1'b1, 1'b0));
    tbl.push_back(mk(4'hB, 16'h8004, 16'h0000, 4'd3, 16'hF000, 4'b1010, 1'b1, 1'b0));
    tbl.push_back(mk(4'h9, 16'h8001, 16'h0000, 4'd1, 16'h0003, 4'b0010, 1'b1, 1'b0));
    tbl.push_back(mk(4'h8, 16'h1234, 16'h0000, 4'd0, 16'h1234, 4'b0000, 1'b1, 1'b0));
    tbl.push_back(mk(4'h8, 16'h0003, 16'h0000, 4'd15, 16'h8000, 4'b1010, 1'b1, 1'b0));
    tbl.push_back(mk(4'hA, 16'h8000, 16'h0000, 4'd15, 16'h0001, 4'b0000, 1'b1, 1'b0));
    tbl.push_back(mk(4'h9, 16'h1234, 16'h0000, 4'd4, 16'h2341, 4'b0010, 1'b1, 1'b0));
    tbl.push_back(mk(4'hB, 16'h7FFF, 16'h0000, 4'd15, 16'h0000, 4'b0110, 1'b1, 1'b0));
    tbl.push_back(mk(4'hF, 16'h1234, 16'h5678, 4'd2, 16'h0000, 4'b0000, 1'b0, 1'b1));
    tbl.push_back(mk(4'h7, 16'hFFFF, 16'hFFFF, 4'd0, 16'h0000, 4'b0000, 1'b0, 1'b1));

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_flags", out_flags, 0);
    chk("rst_wen", out_wen, 0);
    chk("rst_illegal", out_illegal, 0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run_op($sformatf("vec%0d", i), tbl[i], 0);

    // Consumer stall on a completed SUB
    run_op("stall", mk(4'h1, 16'h0003, 16'h0005, 4'd0, 16'hFFFE, 4'b1010, 1'b1, 1'b0), 5);

    // Reset on the 2nd SHIFT cycle of an SRL by 8 aborts it
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 4'hA; in_a = 16'hF00F; in_b = '0; in_shamt = 4'd8;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", out_result, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("abort_no_valid", out_valid, 0);
    end
    run_op("post_abort_add", mk(4'h0, 16'h1234, 16'h1111, 4'd0, 16'h2345, 4'b0000, 1'b1, 1'b0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution unit that consumes the 4-bit ALU operation code produced by the ALU control stage and the operand pair from the register file; returns result, write-enable and S/Z/C/V flags.
- Arithmetic and logic ops complete in one cycle. Shifts and rotates iterate one bit per cycle.
- Sits between the decode/register-read stage and the writeback/flag register, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, datapath width in bits.
- SHW, 4, shift-amount width; must satisfy 2**SHW >= WIDTH.

Ports:
- clk  input  1  single system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  unit can accept an operation.
- in_op  input  4  ALU operation code (op3).
- in_a  input  WIDTH  operand A (Rd value).
- in_b  input  WIDTH  operand B (Rs value).
- in_shamt  input  SHW  shift amount d.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_result  output  WIDTH  result value.
- out_wen  output  1  result is to be written to Rd.
- out_flags  output  4  {S,Z,C,V}.
- out_illegal  output  1  opcode not supported by this unit.

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, out_result=0, out_wen=0, out_flags=0, out_illegal=0.
- Accept: transfer when in_valid && in_ready. in_ready=1 only in IDLE; the unit holds one operation at a time.
- States:
  - IDLE: wait for an accepted transfer.
    - Non-shift op: compute and go to DONE on the next edge (latency 1).
    - Shift op with shamt=0: go to DONE directly.
    - Shift op with shamt>0: load working register and counter, go to SHIFT.
  - SHIFT: one bit per cycle; counter decrements; go to DONE when the counter reaches 1 → DONE after shamt cycles.
  - DONE: out_valid=1, outputs held stable until out_valid && out_ready. Then go to IDLE, out_valid=0 on the next edge. No back-to-back bypass; next accept is at the earliest one cycle later.
- Opcodes (S = result[WIDTH-1] and Z = (result==0) unless noted):
  - 0000 ADD: a+b; C=carry out; V=signed overflow.
  - 0001 SUB: a-b; C=borrow (a<b unsigned); V=signed overflow.
  - 0010 AND, 0011 OR, 0100 XOR: C=V=0.
  - 0101 CMP: flags as SUB; out_result=a-b; out_wen=0.
  - 0110 MOV: result=b; C=V=0.
  - 1000 SLL: logical left. 1001 SLR: rotate left. 1010 SRL: logical right. 1011 SRA: arithmetic right.
  - Shifts: C=last bit shifted/rotated out; C=0 when shamt=0; V=0.
  - out_wen=1 for every legal op except CMP.
  - All other codes (0111, 1100–1111): out_result=0, flags=0, out_wen=0, out_illegal=1; latency 1.
- Boundaries:
  - shamt >= WIDTH: SLL/SRL give 0; SRA gives all sign bits; SLR wraps mod WIDTH per bit.
  - Inputs are captured at accept; later changes to in_* have no effect.
  - Holding out_ready=0 stalls indefinitely with outputs frozen.
  - Reset asserted mid-SHIFT or in DONE aborts the operation; no result is delivered.

Test Plan:
- ADD a=16'h7FFF, b=16'h0001 → one cycle later out_valid, result=16'h8000, S=1,Z=0,C=0,V=1, wen=1.
- SUB a=16'h0003, b=16'h0005 → result=16'hFFFE, S=1,C=1,V=0; CMP same operands → identical flags, wen=0.
- SRA a=16'h8004, shamt=3 → in_ready low for 3 cycles, then result=16'hF000, C=1; SLR a=16'h8001, shamt=1 → 16'h0003, C=1.
- SLL a=16'h1234, shamt=0 → latency 1, result=16'h1234, C=0; shamt=15 on 16'h0003 → 16'h8000, C=1.
- Opcode 1111 → out_illegal=1, wen=0, result=0. Hold out_ready=0 for 5 cycles on any result → outputs stable, in_ready=0 throughout.
- Assert rst on the 2nd cycle of a shamt=8 SRL → out_valid stays 0, in_ready=1 immediately; the next ADD completes normally.
